// File: rtl/rand_seg_display_pkg.sv
// Shared types and constants for the random-number seven-segment display.
package rand_seg_display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CAPT,
      CONV
   } state_t;

   localparam int          NUM_DIGITS = 4;
   localparam logic [7:0]  SEG_BLANK  = 8'hFF;

   // Active-low {dp,g,f,e,d,c,b,a} patterns for 0..F
   localparam logic [7:0] SEG_LUT [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic logic [3:0] dd_adjust(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/rand_seg_display_if.sv
// Button, LFSR value, handshake and display signals of rand_seg_display.
interface rand_seg_display_if;
   logic       btn_i;
   logic       mode_i;
   logic [7:0] din;
   logic       step_o;
   logic       busy_o;
   logic [7:0] seg_o;
   logic [3:0] an_o;

   modport slave  (input  btn_i, mode_i, din, output step_o, busy_o, seg_o, an_o);
   modport master (output btn_i, mode_i, din, input  step_o, busy_o, seg_o, an_o);
endinterface

// File: rtl/rand_seg_display_btn_debounce.sv
// Button synchroniser and debouncer; rise_o pulses once per qualified press.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic rise_o
);

   localparam int             CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0]  CNT_LOAD = CW'(DEBOUNCE_CYC - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;
   logic          rise_q, rise_d;

   // Down-counter reloads on any agreeing sample; toggles state at terminal count
   always_comb begin
      sync_d   = {sync_q[0], btn_i};
      cnt_d    = CNT_LOAD;
      stable_d = stable_q;
      if (sync_q[1] != stable_q) begin
         if (cnt_q == '0) stable_d = ~stable_q;
         else             cnt_d    = cnt_q - 1'b1;
      end
      rise_d = stable_d & ~stable_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         cnt_q    <= CNT_LOAD;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/rand_seg_display.sv
// Steps the upstream LFSR on a button press, converts the captured value to
// BCD and scans it onto a 4-digit active-low seven-segment display.
//
// state | meaning
// IDLE  | waiting for a press; issues step_o
// CAPT  | latch post-step LFSR value, clear BCD shifter
// CONV  | 8 double-dabble iterations, then publish BCD
module rand_seg_display
   import rand_seg_display_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int SCAN_CYC     = 100000
) (
   input  logic               clk,
   input  logic               rst,
   rand_seg_display_if.slave  bus
);

   localparam int SW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

   logic btn_rise;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (bus.btn_i),
      .rise_o (btn_rise)
   );

   state_t                state_q, state_d;
   logic                  step_q, step_d;
   logic                  busy_q, busy_d;
   logic [7:0]            val_q, val_d;
   logic [11:0]           sh_q, sh_d;
   logic [11:0]           bcd_q, bcd_d;
   logic [2:0]            bit_q, bit_d;
   logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
   logic [1:0]            idx_q, idx_d;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [11:0]           adj;
   logic [3:0]            digit;
   logic                  blank;

   always_comb begin
      state_d = state_q;
      step_d  = 1'b0;
      busy_d  = busy_q;
      val_d   = val_q;
      sh_d    = sh_q;
      bcd_d   = bcd_q;
      bit_d   = bit_q;
      adj     = {dd_adjust(sh_q[11:8]), dd_adjust(sh_q[7:4]), dd_adjust(sh_q[3:0])};
      unique case (state_q)
         IDLE: begin
            step_d = btn_rise & ~step_q;
            if (step_q) begin
               state_d = CAPT;
               busy_d  = 1'b1;
            end
         end
         CAPT: begin
            val_d   = bus.din;
            sh_d    = '0;
            bit_d   = '0;
            state_d = CONV;
         end
         CONV: begin
            sh_d  = (adj << 1) | {11'd0, val_q[3'd7 - bit_q]};
            bit_d = bit_q + 3'd1;
            // Display switches only when the whole conversion is done
            if (bit_q == 3'd7) begin
               bcd_d   = sh_d;
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      idx_d      = idx_q;
      if (scan_cnt_q == SW'(SCAN_CYC - 1)) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 2'd1;
      end

      digit = 4'h0;
      blank = 1'b1;
      if (bus.mode_i) begin
         unique case (idx_q)
            2'd0: begin digit = bcd_q[3:0];  blank = 1'b0; end
            2'd1: begin digit = bcd_q[7:4];  blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0); end
            2'd2: begin digit = bcd_q[11:8]; blank = (bcd_q[11:8] == 4'd0); end
            default: blank = 1'b1;
         endcase
      end else begin
         unique case (idx_q)
            2'd0: begin digit = val_q[3:0]; blank = 1'b0; end
            2'd1: begin digit = val_q[7:4]; blank = 1'b0; end
            default: blank = 1'b1;
         endcase
      end
      seg_d = blank ? SEG_BLANK : SEG_LUT[digit];
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         step_q     <= 1'b0;
         busy_q     <= 1'b0;
         val_q      <= '0;
         sh_q       <= '0;
         bcd_q      <= '0;
         bit_q      <= '0;
         scan_cnt_q <= '0;
         idx_q      <= '0;
         seg_q      <= SEG_BLANK;
         an_q       <= '1;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         busy_q     <= busy_d;
         val_q      <= val_d;
         sh_q       <= sh_d;
         bcd_q      <= bcd_d;
         bit_q      <= bit_d;
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign bus.step_o = step_q;
   assign bus.busy_o = busy_q;
   assign bus.seg_o  = seg_q;
   assign bus.an_o   = an_q;

endmodule

// File: tb/tb_rand_seg_display.sv
// Directed self-checking bench for rand_seg_display with a display scoreboard.
module tb_rand_seg_display;

   typedef struct packed {
      logic [3:0][7:0] dec;
      logic [3:0][7:0] hx;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic sel_b;
   always #5 clk = ~clk;

   rand_seg_display_if bus_a ();
   rand_seg_display_if bus_b ();

   rand_seg_display #(.DEBOUNCE_CYC(4), .SCAN_CYC(3)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   rand_seg_display #(.DEBOUNCE_CYC(1), .SCAN_CYC(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   logic [7:0] seg_m;
   logic [3:0] an_m;
   logic       step_m, busy_m;
   assign seg_m  = sel_b ? bus_b.seg_o  : bus_a.seg_o;
   assign an_m   = sel_b ? bus_b.an_o   : bus_a.an_o;
   assign step_m = sel_b ? bus_b.step_o : bus_a.step_o;
   assign busy_m = sel_b ? bus_b.busy_o : bus_a.busy_o;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   logic [7:0] seg_tab [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic exp_t model(input logic [7:0] v);
      exp_t m;
      int h, t, o;
      h = int'(v) / 100;
      t = (int'(v) / 10) % 10;
      o = int'(v) % 10;
      m.dec[0] = seg_tab[o];
      m.dec[1] = (h == 0 && t == 0) ? 8'hFF : seg_tab[t];
      m.dec[2] = (h == 0) ? 8'hFF : seg_tab[h];
      m.dec[3] = 8'hFF;
      m.hx[0]  = seg_tab[v[3:0]];
      m.hx[1]  = seg_tab[v[7:4]];
      m.hx[2]  = 8'hFF;
      m.hx[3]  = 8'hFF;
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_mode(input logic m);
      bus_a.mode_i = m;
      bus_b.mode_i = m;
   endtask

   task automatic scan(output logic [3:0][7:0] d);
      d = 'x;
      repeat (16) begin
         tick();
         case (an_m)
            4'b1110: d[0] = seg_m;
            4'b1101: d[1] = seg_m;
            4'b1011: d[2] = seg_m;
            4'b0111: d[3] = seg_m;
            default: ;
         endcase
      end
   endtask

   task automatic wait_step(input int budget, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (step_m) seen = 1'b1;
      end
   endtask

   task automatic run_conv(input int n, output int busy_n, output int steps_n);
      busy_n  = 0;
      steps_n = 0;
      repeat (n) begin
         tick();
         if (busy_m) busy_n++;
         if (step_m) steps_n++;
      end
   endtask

   task automatic check_both(input string tag);
      exp_t            e;
      logic [3:0][7:0] d;
      chk($sformatf("%s_sb_pending", tag), sb.size(), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      set_mode(1'b1);
      repeat (2) tick();
      scan(d);
      for (int i = 0; i < 4; i++) chk($sformatf("%s_dec_d%0d", tag, i), d[i], e.dec[i]);
      set_mode(1'b0);
      repeat (2) tick();
      scan(d);
      for (int i = 0; i < 4; i++) chk($sformatf("%s_hex_d%0d", tag, i), d[i], e.hx[i]);
      set_mode(1'b1);
   endtask

   task automatic press_a(input logic [7:0] v, input string tag);
      logic seen;
      int   b, s;
      bus_a.btn_i = 1'b1;
      wait_step(20, seen);
      chk($sformatf("%s_step_seen", tag), seen, 1);
      bus_a.din = v;
      sb.push_back(model(v));
      run_conv(14, b, s);
      chk($sformatf("%s_busy_cycles", tag), b, 9);
      chk($sformatf("%s_extra_steps", tag), s, 0);
      bus_a.btn_i = 1'b0;
      repeat (12) tick();
      check_both(tag);
   endtask

   initial begin
      logic [3:0] an_hist [4];
      logic [3:0] prev;
      logic       seen;
      int         n, steps, cyc, k, b, s;

      rst   = 1'b1;
      sel_b = 1'b0;
      bus_a.btn_i = 1'b0; bus_a.mode_i = 1'b1; bus_a.din = 8'h00;
      bus_b.btn_i = 1'b0; bus_b.mode_i = 1'b1; bus_b.din = 8'h00;
      repeat (3) tick();
      chk("rst_seg", seg_m, 8'hFF);
      chk("rst_an", an_m, 4'hF);
      chk("rst_step", step_m, 0);
      chk("rst_busy", busy_m, 0);

      // 1: scan order and reset display
      rst  = 1'b0;
      prev = an_m;
      n    = 0;
      for (int i = 0; i < 4; i++) an_hist[i] = 'x;
      repeat (20) begin
         tick();
         if (an_m != prev && n < 4) begin
            an_hist[n] = an_m;
            n++;
         end
         prev = an_m;
      end
      chk("scan_an0", an_hist[0], 4'b1110);
      chk("scan_an1", an_hist[1], 4'b1101);
      chk("scan_an2", an_hist[2], 4'b1011);
      chk("scan_an3", an_hist[3], 4'b0111);
      sb.push_back(model(8'h00));
      check_both("t1");

      // 2: bounce shorter than the debounce window, then a real press
      cyc = 0; k = 0; steps = 0;
      while (cyc < 50) begin
         bus_a.btn_i = 1'b1;
         repeat (1 + k % 3) begin tick(); cyc++; if (step_m) steps++; end
         bus_a.btn_i = 1'b0;
         repeat (2) begin tick(); cyc++; if (step_m) steps++; end
         k++;
      end
      chk("t2_bounce_steps", steps, 0);
      press_a(8'hFF, "t2");

      // 3, 4: single digit and interior zeros
      press_a(8'h04, "t3");
      press_a(8'h64, "t4");

      // 5: second edge during conversion is dropped (fast debouncer)
      sel_b = 1'b1;
      bus_b.btn_i = 1'b1;
      wait_step(20, seen);
      chk("t5_step_seen", seen, 1);
      bus_b.din = 8'h37;
      sb.push_back(model(8'h37));
      b = 0; s = 0;
      for (int i = 1; i <= 25; i++) begin
         tick();
         if (busy_m) b++;
         if (step_m) s++;
         if (i == 1) bus_b.btn_i = 1'b0;
         if (i == 4) bus_b.btn_i = 1'b1;
      end
      chk("t5_busy_cycles", b, 9);
      chk("t5_extra_steps", s, 0);
      check_both("t5");
      bus_b.btn_i = 1'b0;
      sel_b = 1'b0;
      repeat (4) tick();

      // 6: reset mid-conversion
      bus_a.btn_i = 1'b1;
      wait_step(20, seen);
      chk("t6_step_seen", seen, 1);
      bus_a.din = 8'hC8;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      chk("t6_rst_seg", seg_m, 8'hFF);
      chk("t6_rst_an", an_m, 4'hF);
      chk("t6_rst_busy", busy_m, 0);
      chk("t6_rst_step", step_m, 0);
      bus_a.btn_i = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      sb.push_back(model(8'h00));
      check_both("t6_clr");
      press_a(8'h2A, "t6_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
